// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//
// Multi-cycle instruction sequencer for the cpuy core. Fetches the two-byte
// instruction (opcode, w) from a synchronous program ROM, presents the latched
// bytes to the ucode decoder, then sequences execute, RAM/stack access and
// write-back from the decoder's control outputs. Owns the program counter and
// the stack pointer.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run_en               sequencing enable, looked at only in FETCH
//   rom_addr / rom_data  program ROM interface (data valid one cycle later)
//   opcode, w            latched instruction bytes to the decoder
//   alu_operation .. stack_direction   decoder control inputs
//   mem_req/mem_we/mem_addr/mem_ack    RAM handshake (level req, pulse ack)
//   alu_start, wb_en     one-cycle strobes
//   sp                   stack entry count (0 .. 2^SP_WIDTH)
//   stack_fault          sticky overflow/underflow flag
//   state                current FSM state, for debug
//
// State | meaning
// FETCH | instruction boundary, ROM addressed at pc, wait for run_en
// OPC   | opcode byte arriving, ROM addressed at pc+1
// OPW   | operand byte arriving, pc advanced by 2
// EXEC  | decoder outputs sampled, branch/ALU/access decision
// MEM   | RAM request held until mem_ack
// WB    | write-back strobe
// HALT  | stack fault, left only by reset

module ucode_sequencer #(
    parameter int         PC_WIDTH   = 8,
    parameter int         SP_WIDTH   = 4,
    parameter logic [7:0] STACK_BASE = 8'hF0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_en,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [7:0]          rom_data,
    output logic [7:0]          opcode,
    output logic [7:0]          w,
    input  logic                alu_operation,
    input  logic                jump_operation,
    input  logic                jump_condition,
    input  logic                ram_operand,
    input  logic                destination_memory,
    input  logic                stack_operation,
    input  logic                stack_direction,
    output logic                mem_req,
    output logic                mem_we,
    output logic [7:0]          mem_addr,
    input  logic                mem_ack,
    output logic                alu_start,
    output logic                wb_en,
    output logic [SP_WIDTH:0]   sp,
    output logic                stack_fault,
    output logic [2:0]          state
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_OPC   = 3'd1;
    localparam logic [2:0] S_OPW   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;

    localparam logic [SP_WIDTH:0] SP_FULL = {1'b1, {SP_WIDTH{1'b0}}};

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [SP_WIDTH:0]   sp_q;
    logic [7:0]          opcode_q, w_q, mem_addr_q;
    logic                mem_we_q;
    logic                push_q, pop_q, jump_q;
    logic                fault_q;

    logic                stack_err;
    logic [7:0]          sp_byte;
    logic [7:0]          exec_addr;
    logic                exec_we;
    logic [PC_WIDTH-1:0] jump_target;

    assign sp_byte     = 8'(sp_q);
    assign jump_target = PC_WIDTH'(w_q);

    // Push into a full stack or pop from an empty one.
    always_comb begin
        stack_err = 1'b0;
        if (stack_operation) begin
            stack_err = stack_direction ? (sp_q == SP_FULL) : (sp_q == '0);
        end
    end

    // RAM address/direction for the access decided in EXEC. Stack accesses
    // take precedence over a RAM operand, matching the EXEC branch priority.
    always_comb begin
        exec_addr = w_q;
        exec_we   = destination_memory;
        if (stack_operation) begin
            exec_we   = stack_direction;
            exec_addr = stack_direction ? (STACK_BASE + sp_byte)
                                        : (STACK_BASE + sp_byte - 8'd1);
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (run_en) state_d = S_OPC;
            S_OPC:   state_d = S_OPW;
            S_OPW:   state_d = S_EXEC;
            S_EXEC: begin
                if (stack_operation) begin
                    state_d = stack_err ? S_HALT : S_MEM;
                end else if (ram_operand) begin
                    state_d = S_MEM;
                end else if (jump_operation) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:   if (mem_ack) state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        rom_addr  = pc_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_start = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            S_OPC:  rom_addr  = pc_q + PC_WIDTH'(1);
            S_EXEC: alu_start = alu_operation;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = mem_we_q;
            end
            S_WB:   wb_en = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // The access kind and jump decision are captured in EXEC so the MEM
    // phase does not depend on the decoder staying stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            sp_q       <= '0;
            opcode_q   <= '0;
            w_q        <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            jump_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                S_OPC: opcode_q <= rom_data;
                S_OPW: begin
                    w_q  <= rom_data;
                    pc_q <= pc_q + PC_WIDTH'(2);
                end
                S_EXEC: begin
                    if (stack_err) fault_q <= 1'b1;
                    mem_addr_q <= exec_addr;
                    mem_we_q   <= exec_we;
                    push_q     <= stack_operation & stack_direction;
                    pop_q      <= stack_operation & ~stack_direction;
                    jump_q     <= jump_operation & jump_condition;
                    if (!stack_operation && !ram_operand &&
                        jump_operation && jump_condition) begin
                        pc_q <= jump_target;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (push_q) sp_q <= sp_q + 1'b1;
                        if (pop_q)  sp_q <= sp_q - 1'b1;
                        if (jump_q) pc_q <= jump_target;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode      = opcode_q;
    assign w           = w_q;
    assign mem_addr    = mem_addr_q;
    assign sp          = sp_q;
    assign stack_fault = fault_q;
    assign state       = state_q;

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
Multi-cycle instruction sequencer for the cpuy core. It fetches the two-byte instruction (opcode, w) from synchronous program ROM and latches it to drive the ucode decoder. It samples the decoder's control outputs and sequences execute, memory/stack access and write-back. It owns the program counter and the stack pointer.

Parameters:
PC_WIDTH, 8, program counter / ROM address width
SP_WIDTH, 4, stack depth = 2^SP_WIDTH entries
STACK_BASE, 8'hF0, RAM address of stack entry 0

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run_en  in  1  sequencing enable, sampled in FETCH only
rom_addr  out  PC_WIDTH  program ROM address; synchronous ROM, data valid next cycle
rom_data  in  8  program ROM read data
opcode  out  8  latched opcode to ucode decoder
w  out  8  latched operand byte to ucode decoder
alu_operation  in  1  from decoder
jump_operation  in  1  from decoder
jump_condition  in  1  from decoder, jump taken
ram_operand  in  1  from decoder, RAM access at address w
destination_memory  in  1  from decoder, RAM access is a write
stack_operation  in  1  from decoder
stack_direction  in  1  from decoder, 0 pop, 1 push
mem_req  out  1  RAM request, level, held until ack
mem_we  out  1  RAM write qualifier, valid with mem_req
mem_addr  out  8  RAM address, valid with mem_req
mem_ack  in  1  RAM completion, one-cycle pulse
alu_start  out  1  one-cycle strobe, ALU evaluates latched operands
wb_en  out  1  one-cycle strobe, commit decoder-selected destination
sp  out  SP_WIDTH+1  stack entry count, 0..2^SP_WIDTH
stack_fault  out  1  sticky, set on overflow or underflow
state  out  3  current FSM state, debug

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=0, sp=0, opcode=0, w=0, stack_fault=0. mem_req, mem_we, alu_start and wb_en are 0. mem_addr=0. rom_addr=0. Reset mid-MEM drops mem_req immediately; any pending ack is ignored.
- rom_addr = pc in all states except OPC, where rom_addr = pc+1.
- States: FETCH=0, OPC=1, OPW=2, EXEC=3, MEM=4, WB=5, HALT=6.
- FETCH: if run_en=1, go to OPC; otherwise hold. Idle stops occur only at instruction boundaries.
- OPC: opcode <= rom_data; go to OPW.
- OPW: w <= rom_data; pc <= pc+2, modulo 2^PC_WIDTH with wrap to 0; go to EXEC.
- EXEC: decoder inputs are sampled here and are valid combinationally from the latched opcode/w.
  - alu_start=1 this cycle if alu_operation=1.
  - Priority 1: stack_operation=1.
    - Push with sp=2^SP_WIDTH, or pop with sp=0: set stack_fault, go to HALT, no RAM access.
    - Otherwise go to MEM.
  - Priority 2: ram_operand=1 → go to MEM.
  - Priority 3: jump_operation=1 → if jump_condition=1, pc <= w zero-extended/truncated to PC_WIDTH. Go to FETCH; no WB.
  - Otherwise go to WB.
- MEM: mem_req=1 from the first MEM cycle.
  - Stack push: mem_addr = STACK_BASE+sp, mem_we=1.
  - Stack pop: mem_addr = STACK_BASE+sp-1, mem_we=0.
  - RAM operand: mem_addr = w, mem_we = destination_memory.
  - mem_req, mem_addr and mem_we stay stable until the cycle mem_ack=1.
  - In the ack cycle: push sets sp+1, pop sets sp-1. If jump_operation and jump_condition are both 1, load pc <= w. Then go to WB; mem_req=0 in WB.
  - mem_ack outside MEM is ignored.
- WB: wb_en=1 for one cycle; go to FETCH.
- HALT: all strobes 0; leave only by reset.
- Latency with zero wait states:
  - Plain or ALU instruction: 5 cycles.
  - Jump: 4 cycles.
  - Memory/stack: 6 + wait cycles.
- sp saturates only by fault. All 2^SP_WIDTH entries are usable.

Test Plan:
- ALU op at ROM[0..1], run_en=1 → rom_addr 0,1 issued; alu_start in cycle 4, wb_en in cycle 5; pc=2; next fetch at cycle 6.
- Taken jump, w=0x40 → pc=0x40, no wb_en, next rom_addr=0x40 after 4 cycles. Not-taken jump → pc=2.
- RAM write, w=0x12, destination_memory=1, mem_ack delayed 3 cycles → mem_req/mem_addr=0x12/mem_we=1 stable 4 cycles, then wb_en.
- 16 pushes then a 17th push (SP_WIDTH=4) → pushes write 0xF0..0xFF and sp=16; 17th sets stack_fault, state=HALT, no mem_req. Reset → sp=0, stack_fault=0.
- Pop at sp=0 → stack_fault=1, HALT. Push then pop → pop reads 0xF0, sp back to 0.
- rst_n low during MEM → mem_req=0 asynchronously. After release: pc=0, state=FETCH; run_en=0 holds FETCH indefinitely.
